// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MIPS byte/half/word load-store unit in front of a word-only DataMemory
//
// Purpose:
//   Turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
//   Load results are sign/zero-extended. Sub-word stores become a read-modify-write
//   because DataMemory has no byte enables. Busy stalls the pipeline while an access
//   is in flight.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word or Size=11 drops the request and pulses Fault
//   undefined : Fault tied 0, Size=11 behaves as word, misaligned addresses align down
//
// Ports:
//   Clock, Reset_n        clock, asynchronous active-low reset
//   Req, Write, Size,     request handshake and fields, sampled only in IDLE
//   Unsigned, Addr,
//   StoreData
//   Busy                  high whenever the FSM is not IDLE
//   LoadData, LoadValid   extended load result and its one-cycle valid pulse
//   Fault                 one-cycle pulse for a dropped illegal request
//   MemAddress, MemWriteData, MemRead, MemWrite   registered DataMemory controls
//   MemReadData           combinational read data from DataMemory

module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Req,
  input  logic              Write,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] StoreData,
  output logic              Busy,
  output logic [DATA_W-1:0] LoadData,
  output logic              LoadValid,
  output logic              Fault,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemReadData
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4
`ifdef LSU_MISALIGN_TRAP_EN
    ,S_FAULT = 3'd5
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_accept;
  logic [1:0]  w_size_eff;

  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [15:0] r_store_data;

  logic [7:0]        w_rd_byte;
  logic [15:0]       w_rd_half;
  logic [DATA_W-1:0] w_load_ext;
  logic [DATA_W-1:0] w_merged;

  // Reserved size collapses onto word; with the trap enabled it never gets this far.
  assign w_size_eff = (Size == 2'b11) ? SZ_WORD : Size;

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_illegal;
  assign w_illegal = (Size == 2'b11) ||
                     ((Size == SZ_HALF) && Addr[0]) ||
                     ((Size == SZ_WORD) && (Addr[1:0] != 2'b00));
`endif

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Req) begin
          w_accept = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          if (w_illegal)
            w_next_state = S_FAULT;
          else
`endif
          if (!Write)
            w_next_state = S_LOAD;
          else if (w_size_eff == SZ_WORD)
            w_next_state = S_STORE;
          else
            w_next_state = S_RMW_RD;
        end
      end
      S_RMW_RD: w_next_state = S_RMW_WR;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane replacement for read-modify-write.
  // Halfwords always use Addr[1] as the lane, so a misaligned half aligns down.
  always_comb begin
    w_rd_byte = MemReadData[{r_lane, 3'b000} +: 8];
    w_rd_half = r_lane[1] ? MemReadData[31:16] : MemReadData[15:0];

    case (r_size)
      SZ_BYTE: w_load_ext = r_unsigned ? {24'h0, w_rd_byte} : {{24{w_rd_byte[7]}}, w_rd_byte};
      SZ_HALF: w_load_ext = r_unsigned ? {16'h0, w_rd_half} : {{16{w_rd_half[15]}}, w_rd_half};
      default: w_load_ext = MemReadData;
    endcase

    w_merged = MemReadData;
    if (r_size == SZ_BYTE)
      w_merged[{r_lane, 3'b000} +: 8] = r_store_data[7:0];
    else if (r_lane[1])
      w_merged[31:16] = r_store_data;
    else
      w_merged[15:0] = r_store_data;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  // Registered outputs and captured request fields. Strobes are decoded from the
  // next state so they line up with the state they belong to.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Busy         <= 1'b0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      LoadValid    <= 1'b0;
      LoadData     <= '0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_lane       <= 2'b00;
      r_store_data <= 16'h0;
    end else begin
      Busy      <= (w_next_state != S_IDLE);
      MemRead   <= (w_next_state == S_LOAD)  || (w_next_state == S_RMW_RD);
      MemWrite  <= (w_next_state == S_STORE) || (w_next_state == S_RMW_WR);
      LoadValid <= (r_state == S_LOAD);

      if (w_accept) begin
        r_size       <= w_size_eff;
        r_unsigned   <= Unsigned;
        r_lane       <= Addr[1:0];
        r_store_data <= StoreData[15:0];
        MemAddress   <= {2'b00, Addr[ADDR_W-1:2]};
        if (w_next_state == S_STORE)
          MemWriteData <= StoreData;
      end

      if (r_state == S_LOAD)
        LoadData <= w_load_ext;

      // The merged word doubles as the merge register: it is ready and stable
      // for the whole RMW_WR strobe cycle.
      if (r_state == S_RMW_RD)
        MemWriteData <= w_merged;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      Fault <= 1'b0;
    else
      Fault <= (w_next_state == S_FAULT);
  end
`else
  assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard testbench for load_store_unit with a word-only memory stub
module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Req;
  logic        Write;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        Busy;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        Fault;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemReadData;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];

  logic [31:0] exp_ld_q   [$];
  logic [3:0]  exp_wa_q   [$];
  logic [31:0] exp_wd_q   [$];
  int          exp_flt_q  [$];

  load_store_unit dut (
    .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .Write(Write), .Size(Size),
    .Unsigned(Unsigned), .Addr(Addr), .StoreData(StoreData), .Busy(Busy),
    .LoadData(LoadData), .LoadValid(LoadValid), .Fault(Fault),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;

  assign MemReadData = mem[MemAddress[3:0]];
  always @(posedge Clock) if (MemWrite) mem[MemAddress[3:0]] <= MemWriteData;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] lo, input logic [31:0] sd);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) r[8*lo +: 8] = sd[7:0];
    else if (lo[1])  r[31:16] = sd[15:0];
    else             r[15:0]  = sd[15:0];
    return r;
  endfunction

  function automatic logic model_illegal(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Output monitor: pops the scoreboard on every result the DUT produces.
  always @(negedge Clock) begin
    check_eq("strobe_excl", {31'h0, MemRead & MemWrite}, 32'h0);
    if (LoadValid) begin
      if (exp_ld_q.size() == 0) check_eq("ld_spurious", {31'h0, LoadValid}, 32'h0);
      else check_eq("load_data", LoadData, exp_ld_q.pop_front());
    end
    if (MemWrite) begin
      wr_count++;
      if (exp_wd_q.size() == 0) check_eq("wr_spurious", {31'h0, MemWrite}, 32'h0);
      else begin
        check_eq("wr_addr", MemAddress, {28'h0, exp_wa_q.pop_front()});
        check_eq("wr_data", MemWriteData, exp_wd_q.pop_front());
      end
    end
    if (Fault) begin
      if (exp_flt_q.size() == 0) check_eq("flt_spurious", {31'h0, Fault}, 32'h0);
      else void'(exp_flt_q.pop_front());
    end
  end

  // Called on a negedge with Busy low; returns on the negedge of the first IDLE cycle.
  task automatic do_op(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] sd);
    logic [3:0]  idx;
    logic        flt;
    logic        rmw;
    logic [31:0] nw;
    idx = a[5:2];
    flt = model_illegal(sz, a);
    rmw = wr && (sz == 2'b00 || sz == 2'b01) && !flt;
    if (flt) exp_flt_q.push_back(1);
    else if (!wr) exp_ld_q.push_back(model_load(ref_mem[idx], sz, uns, a[1:0]));
    else begin
      nw = rmw ? model_merge(ref_mem[idx], sz, a[1:0], sd) : sd;
      exp_wa_q.push_back(idx);
      exp_wd_q.push_back(nw);
      ref_mem[idx] = nw;
    end
    Req = 1'b1; Write = wr; Size = sz; Unsigned = uns; Addr = a; StoreData = sd;
    @(posedge Clock);
    @(negedge Clock);
    Req = 1'b0;
    check_eq("busy_c1", {31'h0, Busy}, 32'h1);
    if (flt) begin
      check_eq("fault_c1", {31'h0, Fault}, 32'h1);
      check_eq("flt_no_strobe", {30'h0, MemRead, MemWrite}, 32'h0);
    end else if (!wr) begin
      check_eq("ld_rd_c1", {30'h0, MemRead, MemWrite}, 32'h2);
      check_eq("ld_addr", MemAddress, {28'h0, idx});
    end else if (!rmw) begin
      check_eq("sw_wr_c1", {30'h0, MemRead, MemWrite}, 32'h1);
    end else begin
      check_eq("rmw_rd_c1", {30'h0, MemRead, MemWrite}, 32'h2);
      check_eq("rmw_addr", MemAddress, {28'h0, idx});
      @(negedge Clock);
      check_eq("busy_c2", {31'h0, Busy}, 32'h1);
      check_eq("rmw_wr_c2", {30'h0, MemRead, MemWrite}, 32'h1);
    end
    @(negedge Clock);
    check_eq("busy_end", {31'h0, Busy}, 32'h0);
    if (!wr && !flt) check_eq("lv_c2", {31'h0, LoadValid}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    Reset_n = 1'b0; Req = 1'b0; Write = 1'b0; Size = 2'b00; Unsigned = 1'b0;
    Addr = 32'h0; StoreData = 32'h0;
    repeat (3) @(negedge Clock);
    check_eq("rst_ctl", {27'h0, Busy, LoadValid, Fault, MemRead, MemWrite}, 32'h0);
    check_eq("rst_ld", LoadData, 32'h0);
    check_eq("rst_wd", MemWriteData, 32'h0);
    check_eq("rst_addr", MemAddress, 32'h0);
    Reset_n = 1'b1;
    @(negedge Clock);

    // Word store then load
    do_op(1, 2'b10, 0, 32'h8, 32'h12345678);
    do_op(0, 2'b10, 0, 32'h8, 32'h0);
    check_eq("lw_0x8_value", LoadData, 32'h12345678);
    // Byte loads
    do_op(0, 2'b00, 0, 32'hB, 32'h0);
    check_eq("lb_0xB_value", LoadData, 32'h00000012);
    do_op(0, 2'b00, 1, 32'h8, 32'h0);
    do_op(1, 2'b10, 0, 32'h8, 32'h000080F0);
    do_op(0, 2'b00, 0, 32'h8, 32'h0);
    check_eq("lb_neg_value", LoadData, 32'hFFFFFFF0);
    do_op(0, 2'b01, 1, 32'h8, 32'h0);
    do_op(0, 2'b01, 0, 32'h8, 32'h0);
    check_eq("lh_neg_value", LoadData, 32'hFFFF80F0);
    // Sub-word read-modify-write
    do_op(1, 2'b10, 0, 32'hC, 32'hAABBCCDD);
    do_op(1, 2'b00, 0, 32'hD, 32'h00000011);
    check_eq("sb_mem", mem[3], 32'hAABB11DD);
    do_op(1, 2'b01, 0, 32'hE, 32'h00005566);
    check_eq("sh_mem", mem[3], 32'h556611DD);
    // Misaligned / reserved size
    do_op(1, 2'b10, 0, 32'h4, 32'hCAFEF00D);
    do_op(0, 2'b10, 0, 32'h6, 32'h0);
    do_op(1, 2'b01, 0, 32'h9, 32'h0000BEEF);
    do_op(0, 2'b11, 0, 32'h4, 32'h0);
    check_eq("misalign_mem2", mem[2], ref_mem[2]);

    // Handshake: Req held through Busy yields one access; next accept on first IDLE cycle
    begin
      int w0;
      w0 = wr_count;
      exp_wa_q.push_back(4'h8); exp_wd_q.push_back(32'h0BADBEEF); ref_mem[8] = 32'h0BADBEEF;
      Req = 1'b1; Write = 1'b1; Size = 2'b10; Unsigned = 1'b0; Addr = 32'h20; StoreData = 32'h0BADBEEF;
      @(negedge Clock);
      check_eq("hs_busy_c1", {31'h0, Busy}, 32'h1);
      @(negedge Clock);
      check_eq("hs_idle_c2", {31'h0, Busy}, 32'h0);
      exp_ld_q.push_back(32'h0BADBEEF);
      Write = 1'b0;
      @(negedge Clock);
      Req = 1'b0;
      check_eq("hs_rd_c3", {30'h0, MemRead, MemWrite}, 32'h2);
      check_eq("hs_one_write", wr_count - w0, 1);
      @(negedge Clock);
      check_eq("hs_lv", {31'h0, LoadValid}, 32'h1);
    end

    // Reset during RMW_RD of SB 0xC
    Req = 1'b1; Write = 1'b1; Size = 2'b00; Unsigned = 1'b0; Addr = 32'hC; StoreData = 32'h77;
    @(posedge Clock);
    @(negedge Clock);
    Req = 1'b0;
    check_eq("rst_rmw_rd", {30'h0, MemRead, MemWrite}, 32'h2);
    Reset_n = 1'b0;
    #1;
    check_eq("rst_mid_ctl", {27'h0, Busy, LoadValid, Fault, MemRead, MemWrite}, 32'h0);
    check_eq("rst_mid_wd", MemWriteData, 32'h0);
    check_eq("rst_mid_addr", MemAddress, 32'h0);
    check_eq("rst_mid_ld", LoadData, 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clock);
    check_eq("rst_mem3", mem[3], 32'h556611DD);
    do_op(0, 2'b10, 0, 32'hC, 32'h0);

    // Random mix over a 16-word window
    for (int i = 0; i < 40; i++)
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)), $urandom);
    for (int i = 0; i < 16; i++) check_eq("final_mem", mem[i], ref_mem[i]);

    repeat (3) @(negedge Clock);
    check_eq("sb_drain", exp_ld_q.size() + exp_wd_q.size() + exp_flt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
